// File: rtl/ram_hs_pkg.sv
// ram_hs_pkg: shared types and helpers for the ram_hs block RAM.
//   state_t    : handshake FSM states
//   RD_LAT_MAX : deepest supported read pipeline
//   CNT_W      : width of the read-latency counter
//   clog2()    : constant ceil(log2) for deriving address widths
package ram_hs_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, GAP} state_t;

  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ram_hs_if.sv
// ram_hs_if: picorv32-native memory bus (valid/ready handshake).
//   master : drives mem_valid/mem_addr/mem_wdata/mem_wstrb, receives
//            mem_ready/mem_rdata/mem_err
//   slave  : the opposite direction
interface ram_hs_if #(
  parameter int DW = 32
) ();
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic            mem_err;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata, mem_err);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata, mem_err);
endinterface

// File: rtl/ram_hs_array.sv
// ram_hs_array: DW x DEPTH storage with per-byte write enables.
// A read is registered into stage 0 and then walks RD_LAT-1 further stages,
// so data appears RD_LAT-1 cycles after the read clock edge. Storage is never
// reset; the output pipeline is.
//   clk, rst_n : clock, async active-low reset (pipeline only)
//   i_we, i_be : write enable and byte enables
//   i_re       : read enable (loads stage 0)
//   i_idx      : word index
//   i_wdata    : write data
//   o_rdata    : last pipeline stage; holds until the next read reaches it
module ram_hs_array #(
  parameter int DW     = 32,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 1,
  parameter int AW     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic            i_re,
  input  logic [AW-1:0]   i_idx,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata
);
  localparam int NB = DW / 8;

  logic [NB-1:0][7:0] r_mem  [DEPTH];
  logic [DW-1:0]      r_pipe [RD_LAT];

  always_ff @(posedge clk)
    if (i_we)
      for (int b = 0; b < NB; b++)
        if (i_be[b]) r_mem[i_idx][b] <= i_wdata[b*8 +: 8];

  // Stage 0 only moves on a read, so once a result has drained to the end
  // every stage holds it and o_rdata stays stable between reads.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      if (i_re) r_pipe[0] <= r_mem[i_idx];
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end

  assign o_rdata = r_pipe[RD_LAT-1];
endmodule

// File: rtl/ram_hs.sv
// ram_hs: parametrised byte-write block RAM on a picorv32 valid/ready bus.
// Decodes BASE_ADDR..BASE_ADDR+DEPTH*NB-1, flags out-of-range accesses with
// mem_err, and supports a read latency of RD_LAT (1..4) cycles.
//   clk, resetn : clock, async active-low reset
//   bus         : ram_hs_if.slave (mem_valid/addr/wdata/wstrb in,
//                 mem_ready/rdata/err out)
//   rd_cnt, wr_cnt : successful read/write counters, present only when
//                    RAM_HS_STATS_EN is defined
module ram_hs
  import ram_hs_pkg::*;
#(
  parameter int          DW        = 32,
  parameter int          DEPTH     = 65536,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    resetn,
  ram_hs_if.slave bus
`ifdef RAM_HS_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);
  localparam int NB  = DW / 8;
  localparam int OFS = clog2(NB);
  localparam int AW  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_err;

  // 33-bit subtract: bit 32 set means the address is below BASE_ADDR.
  logic [32:0]   w_diff;
  logic [31:0]   w_idx;
  logic          w_in_range;
  logic          w_is_wr;
  logic          w_accept;
  logic          w_we;
  logic          w_re;
  logic [DW-1:0] w_arr_q;

  assign w_diff     = {1'b0, bus.mem_addr} - {1'b0, BASE_ADDR};
  assign w_idx      = w_diff[31:0] >> OFS;
  assign w_in_range = !w_diff[32] && (w_idx < 32'(DEPTH));
  assign w_is_wr    = |bus.mem_wstrb;
  assign w_accept   = (r_state == IDLE) && bus.mem_valid;

  // The storage has no reset, so gate the write with resetn: a request
  // landing on the same edge that reset asserts must not write.
  assign w_we = w_accept && w_in_range && w_is_wr && resetn;
  assign w_re = w_accept && w_in_range && !w_is_wr;

  ram_hs_array #(
    .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .AW(AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (resetn),
    .i_we    (w_we),
    .i_be    (bus.mem_wstrb),
    .i_re    (w_re),
    .i_idx   (w_idx[AW-1:0]),
    .i_wdata (bus.mem_wdata),
    .o_rdata (w_arr_q)
  );

  // r_ready/r_err are set on the edge entering RESP and cleared on the next,
  // so both are single-cycle pulses aligned with the RESP state.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.mem_valid) begin
            if (!w_in_range || w_is_wr || RD_LAT == 1) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= !w_in_range;
            end else begin
              r_state <= RD_WAIT;
              r_cnt   <= CNT_W'(RD_LAT - 1);
            end
          end
        RD_WAIT:
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= RESP;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        RESP:    r_state <= GAP;
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  assign bus.mem_ready = r_ready;
  assign bus.mem_err   = r_err;
  // Error responses read as zero; otherwise the array output is shown, and
  // it holds the last read result between reads.
  assign bus.mem_rdata = r_err ? '0 : w_arr_q;

`ifdef RAM_HS_STATS_EN
  logic        r_wr;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wr     <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_accept) r_wr <= w_is_wr;
      if (r_ready && !r_err) begin
        if (r_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
        else      r_rd_cnt <= r_rd_cnt + 32'd1;
      end
    end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif
endmodule

// File: tb/tb_ram_hs.sv
// tb_ram_hs: three ram_hs instances (RD_LAT 1/3/4, different bases/depths)
// share one stimulus bus; only the selected instance sees mem_valid.
// Expected results come from a word-indexed associative-array model.
module tb_ram_hs;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          sel = 0;
  logic        t_valid = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [3:0]  t_wstrb = '0;

  ram_hs_if #(.DW(32)) b0 ();
  ram_hs_if #(.DW(32)) b1 ();
  ram_hs_if #(.DW(32)) b2 ();

  assign b0.mem_valid = t_valid && (sel == 0);
  assign b1.mem_valid = t_valid && (sel == 1);
  assign b2.mem_valid = t_valid && (sel == 2);
  assign b0.mem_addr = t_addr;  assign b0.mem_wdata = t_wdata;  assign b0.mem_wstrb = t_wstrb;
  assign b1.mem_addr = t_addr;  assign b1.mem_wdata = t_wdata;  assign b1.mem_wstrb = t_wstrb;
  assign b2.mem_addr = t_addr;  assign b2.mem_wdata = t_wdata;  assign b2.mem_wstrb = t_wstrb;

`ifdef RAM_HS_STATS_EN
  logic [31:0] rc0, wc0, rc1, wc1, rc2, wc2;
`endif

  ram_hs #(.DW(32), .DEPTH(1024), .RD_LAT(1), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .resetn(resetn), .bus(b0)
`ifdef RAM_HS_STATS_EN
    , .rd_cnt(rc0), .wr_cnt(wc0)
`endif
  );
  ram_hs #(.DW(32), .DEPTH(1000), .RD_LAT(3), .BASE_ADDR(32'h0000_1000)) u1 (
    .clk(clk), .resetn(resetn), .bus(b1)
`ifdef RAM_HS_STATS_EN
    , .rd_cnt(rc1), .wr_cnt(wc1)
`endif
  );
  ram_hs #(.DW(32), .DEPTH(64), .RD_LAT(4), .BASE_ADDR(32'h0000_0100)) u2 (
    .clk(clk), .resetn(resetn), .bus(b2)
`ifdef RAM_HS_STATS_EN
    , .rd_cnt(rc2), .wr_cnt(wc2)
`endif
  );

  logic        o_ready, o_err;
  logic [31:0] o_rdata;
  always_comb begin
    o_ready = b0.mem_ready; o_err = b0.mem_err; o_rdata = b0.mem_rdata;
    case (sel)
      1: begin o_ready = b1.mem_ready; o_err = b1.mem_err; o_rdata = b1.mem_rdata; end
      2: begin o_ready = b2.mem_ready; o_err = b2.mem_err; o_rdata = b2.mem_rdata; end
      default: ;
    endcase
  end

  function automatic logic [31:0] base_of(input int s);
    case (s) 0: return 32'h0; 1: return 32'h1000; default: return 32'h100; endcase
  endfunction
  function automatic int depth_of(input int s);
    case (s) 0: return 1024; 1: return 1000; default: return 64; endcase
  endfunction
  function automatic int lat_of(input int s);
    case (s) 0: return 1; 1: return 3; default: return 4; endcase
  endfunction

  // Reference memory: key = instance*100000 + word index; absent = unknown.
  logic [31:0] model [int];

  function automatic void expect_op(input int s, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] st, output int e_lat, output logic e_err,
                                    output logic [31:0] e_rd, output bit e_known);
    longint      off;
    bit          inr;
    int          key;
    logic [31:0] w;
    off = longint'(a) - longint'(base_of(s));
    inr = (off >= 0) && ((off / 4) < longint'(depth_of(s)));
    key = inr ? s * 100000 + int'(off / 4) : -1;
    e_err = !inr;
    e_lat = (inr && st == 4'h0) ? lat_of(s) : 1;
    e_rd = 32'h0;
    e_known = 1'b1;
    if (inr && st == 4'h0) begin
      if (model.exists(key)) e_rd = model[key];
      else e_known = 1'b0;
    end
    if (inr && st != 4'h0 && (model.exists(key) || st == 4'hF)) begin
      w = model.exists(key) ? model[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      model[key] = w;
    end
  endfunction

  // One bus transaction. lat = cycles from accept edge to mem_ready high
  // (0 if no response within the budget). While waiting, the request inputs
  // are scrambled to show they are not re-sampled after accept.
  task automatic access(input int s, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output logic err,
                        output logic [31:0] rd);
    @(negedge clk);
    sel = s; t_addr = a; t_wdata = wd; t_wstrb = st; t_valid = 1'b1;
    @(posedge clk);
    lat = 0; err = 1'bx; rd = 'x;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (o_ready === 1'b1) begin
        lat = k; err = o_err; rd = o_rdata;
      end else begin
        t_addr  = base_of(s) + 32'($urandom_range(0, 15) * 4);
        t_wdata = $urandom;
        t_wstrb = 4'($urandom);
      end
    end
    @(posedge clk);
    t_valid = 1'b0;
    @(posedge clk);
  endtask

  int          lat, e_lat;
  logic        err, e_err;
  logic [31:0] rd, e_rd;
  bit          e_known;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", s, o_ready); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", s, o_err); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", s, o_rdata); end
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_basic();
    expect_op(0, 32'h10, 32'hDEADBEEF, 4'hF, e_lat, e_err, e_rd, e_known);
    access(0, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, rd);
    total++; if (lat !== 1) begin bad++; $display("FAIL basic_wr_lat got=%0d exp=1", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_wr_err got=%b exp=0", err); end
    expect_op(0, 32'h10, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(0, 32'h10, 32'h0, 4'h0, lat, err, rd);
    total++; if (lat !== 1) begin bad++; $display("FAIL basic_rd_lat got=%0d exp=1", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_rd_err got=%b exp=0", err); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_strobe();
    expect_op(0, 32'h20, 32'h11223344, 4'hF, e_lat, e_err, e_rd, e_known);
    access(0, 32'h20, 32'h11223344, 4'hF, lat, err, rd);
    expect_op(0, 32'h20, 32'hAABBCCDD, 4'b0101, e_lat, e_err, e_rd, e_known);
    access(0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, err, rd);
    total++; if (lat !== 1) begin bad++; $display("FAIL strobe_wr_lat got=%0d exp=1", lat); end
    expect_op(0, 32'h20, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(0, 32'h20, 32'h0, 4'h0, lat, err, rd);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_rd_data got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_latency();
    expect_op(1, 32'h100C, 32'h0BADBEEF, 4'hF, e_lat, e_err, e_rd, e_known);
    access(1, 32'h100C, 32'h0BADBEEF, 4'hF, lat, err, rd);
    expect_op(1, 32'h1008, 32'hCAFEF00D, 4'hF, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1008, 32'hCAFEF00D, 4'hF, lat, err, rd);
    expect_op(1, 32'h1008, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1008, 32'h0, 4'h0, lat, err, rd);
    total++; if (lat !== 3) begin bad++; $display("FAIL lat3_rd_lat got=%0d exp=3", lat); end
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL lat3_rd_data got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_range();
    expect_op(1, 32'h1000, 32'h01020304, 4'hF, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1000, 32'h01020304, 4'hF, lat, err, rd);
    expect_op(1, 32'h1000 + 4*999, 32'h99990999, 4'hF, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1000 + 4*999, 32'h99990999, 4'hF, lat, err, rd);
    expect_op(1, 32'h1000 + 4*1000, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1000 + 4*1000, 32'h0, 4'h0, lat, err, rd);
    total++; if (lat !== 1) begin bad++; $display("FAIL oor_rd_lat got=%0d exp=1", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", err); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
    expect_op(1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, e_lat, e_err, e_rd, e_known);
    access(1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, lat, err, rd);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL below_wr_err got=%b exp=1", err); end
    expect_op(1, 32'h1000, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1000, 32'h0, 4'h0, lat, err, rd);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL below_wr_unchanged got=%h exp=01020304", rd); end
    expect_op(1, 32'h1000 + 4*999, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(1, 32'h1000 + 4*999, 32'h0, 4'h0, lat, err, rd);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_rd_err got=%b exp=0", err); end
    total++; if (rd !== 32'h99990999) begin bad++; $display("FAIL last_rd_data got=%h exp=99990999", rd); end
  endtask

  // Random traffic around both ends of each instance's window, including
  // back-to-back write/read pairs and unaligned low address bits.
  task automatic test_random();
    int          idx;
    logic [31:0] a, wd;
    logic [3:0]  st;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 11; j++) begin
        idx = (j < 6) ? j - 2 : depth_of(s) - 3 + (j - 6);
        if (idx >= 0 && idx < depth_of(s)) begin
          a = base_of(s) + 32'(4 * idx); wd = $urandom;
          expect_op(s, a, wd, 4'hF, e_lat, e_err, e_rd, e_known);
          access(s, a, wd, 4'hF, lat, err, rd);
        end
      end
      for (int n = 0; n < 40; n++) begin
        idx = $urandom_range(0, 10);
        idx = (idx < 6) ? idx - 2 : depth_of(s) - 3 + (idx - 6);
        a  = base_of(s) + 32'(4 * idx) + 32'($urandom_range(0, 3));
        wd = $urandom;
        st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        expect_op(s, a, wd, st, e_lat, e_err, e_rd, e_known);
        access(s, a, wd, st, lat, err, rd);
        total++; if (lat !== e_lat) begin bad++; $display("FAIL rand_lat s=%0d a=%h got=%0d exp=%0d", s, a, lat, e_lat); end
        total++; if (err !== e_err) begin bad++; $display("FAIL rand_err s=%0d a=%h got=%b exp=%b", s, a, err, e_err); end
        if (st == 4'h0 && e_known) begin
          total++; if (rd !== e_rd) begin bad++; $display("FAIL rand_rdata s=%0d a=%h got=%h exp=%h", s, a, rd, e_rd); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    expect_op(2, 32'h104, 32'h5A5A1234, 4'hF, e_lat, e_err, e_rd, e_known);
    access(2, 32'h104, 32'h5A5A1234, 4'hF, lat, err, rd);
    @(negedge clk);
    sel = 2; t_addr = 32'h104; t_wstrb = 4'h0; t_valid = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    resetn = 1'b0; t_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (o_ready !== 1'b0) seen = 1'b1; end
    resetn = 1'b1;
    repeat (6) begin @(negedge clk); if (o_ready !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_ready got=%b exp=0", seen); end
    expect_op(2, 32'h104, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(2, 32'h104, 32'h0, 4'h0, lat, err, rd);
    total++; if (lat !== 4) begin bad++; $display("FAIL rstmid_rd_lat got=%0d exp=4", lat); end
    total++; if (rd !== 32'h5A5A1234) begin bad++; $display("FAIL rstmid_rd_data got=%h exp=5a5a1234", rd); end
  endtask

`ifdef RAM_HS_STATS_EN
  // Counters were cleared by the reset in test_reset_mid.
  task automatic test_stats();
    for (int i = 0; i < 3; i++) begin
      expect_op(0, 32'h400 + 32'(4*i), 32'(i), 4'hF, e_lat, e_err, e_rd, e_known);
      access(0, 32'h400 + 32'(4*i), 32'(i), 4'hF, lat, err, rd);
    end
    for (int i = 0; i < 2; i++) begin
      expect_op(0, 32'h400, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
      access(0, 32'h400, 32'h0, 4'h0, lat, err, rd);
    end
    expect_op(0, 32'h10000, 32'h0, 4'h0, e_lat, e_err, e_rd, e_known);
    access(0, 32'h10000, 32'h0, 4'h0, lat, err, rd);
    total++; if (wc0 !== 32'd3) begin bad++; $display("FAIL stats_wr_cnt got=%0d exp=3", wc0); end
    total++; if (rc0 !== 32'd2) begin bad++; $display("FAIL stats_rd_cnt got=%0d exp=2", rc0); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_strobe();
    test_latency();
    test_range();
    test_random();
    test_reset_mid();
`ifdef RAM_HS_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
